// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: issues icache requests, holds on decode backpressure, flushes on redirect.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 icache_resp_valid,
    input  logic                 decode_ready,
    input  logic                 hazard_stall,
    input  logic                 redirect,
    output logic                 icache_req,
    output logic                 fetch_enable_control,
    output logic                 fetch_stall_control,
    output logic                 instr_valid,
    output logic                 flush,
    output logic                 busy,
    output logic                 timeout_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_fetch_cnt
`endif
);

    if (TIMEOUT_CYCLES < 2 || (2 ** TO_WIDTH) <= TIMEOUT_CYCLES || CNT_WIDTH < 1) begin : g_bad_params
        $error("fetch_controller: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FLUSH
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [TO_WIDTH-1:0] to_cnt;
    logic                drop_pending;
    logic                timeout_q;
    logic                resp_live;
    logic                accept;

    // A response counts only in WAIT and only if it is not the stale answer to a flushed request.
    assign resp_live = (state == S_WAIT) && icache_resp_valid && !drop_pending;
    assign accept    = (resp_live || (state == S_HOLD)) && decode_ready && !hazard_stall;

    // NOTE: every output is assigned a default first so this block can never infer a latch.
    always_comb begin
        icache_req           = 1'b0;
        fetch_enable_control = 1'b0;
        fetch_stall_control  = 1'b0;
        instr_valid          = 1'b0;
        flush                = 1'b0;
        busy                 = 1'b0;
        timeout_err          = 1'b0;
        if (!rst) begin
            icache_req           = (state == S_REQ);
            fetch_enable_control = accept || (state == S_FLUSH);
            fetch_stall_control  = ((state == S_HOLD) || (state == S_WAIT)) && !fetch_enable_control;
            instr_valid          = (state == S_HOLD) || resp_live;
            flush                = (state == S_FLUSH);
            busy                 = (state != S_IDLE);
            timeout_err          = timeout_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            drop_pending <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state <= S_REQ;
                end
                S_REQ: begin
                    to_cnt <= '0;
                    if (redirect) begin
                        state        <= S_FLUSH;
                        drop_pending <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        state        <= S_FLUSH;
                        drop_pending <= !icache_resp_valid;
                    end else if (!icache_resp_valid) begin
                        if (to_cnt == TO_LAST) begin
                            timeout_q <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else if (drop_pending) begin
                        drop_pending <= 1'b0;
                        state        <= S_REQ;
                    end else if (accept) begin
                        state <= S_REQ;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect)    state <= S_FLUSH;
                    else if (accept) state <= S_REQ;
                end
                S_FLUSH: begin
                    // The stale response may land here; it is swallowed and no longer expected.
                    if (icache_resp_valid) drop_pending <= 1'b0;
                    state <= redirect ? S_FLUSH : S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_fetch_cnt <= '0;
        end else begin
            if ((state == S_HOLD) && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (accept && (perf_fetch_cnt != '1))            perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch sequencing rules.
module tb_fetch_controller;

    localparam int TIMEOUT  = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, start, icache_resp_valid, decode_ready, hazard_stall, redirect;
    logic icache_req, fetch_enable_control, fetch_stall_control, instr_valid, flush, busy, timeout_err;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cnt, perf_fetch_cnt;
`endif
    logic [6:0] dut_outs;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    string m_state;
    int    m_waited;
    bit    m_drop, m_terr;
    int    m_stall, m_fetch;

    always #5 clk = ~clk;

    fetch_controller #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_WIDTH      (4),
        .CNT_WIDTH     (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .icache_resp_valid   (icache_resp_valid),
        .decode_ready        (decode_ready),
        .hazard_stall        (hazard_stall),
        .redirect            (redirect),
        .icache_req          (icache_req),
        .fetch_enable_control(fetch_enable_control),
        .fetch_stall_control (fetch_stall_control),
        .instr_valid         (instr_valid),
        .flush               (flush),
        .busy                (busy),
        .timeout_err         (timeout_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt      (perf_stall_cnt),
        .perf_fetch_cnt      (perf_fetch_cnt)
`endif
    );

    assign dut_outs = {icache_req, fetch_enable_control, fetch_stall_control,
                       instr_valid, flush, busy, timeout_err};

    function automatic bit model_accept();
        bit live;
        live = (m_state == "WAIT") && icache_resp_valid && !m_drop;
        return (live || m_state == "HOLD") && decode_ready && !hazard_stall;
    endfunction

    function automatic logic [6:0] exp_outs();
        bit fen, fst, iv;
        if (rst) return 7'b0;
        fen = model_accept() || (m_state == "FLUSH");
        fst = (m_state == "HOLD" || m_state == "WAIT") && !fen;
        iv  = (m_state == "HOLD") || ((m_state == "WAIT") && icache_resp_valid && !m_drop);
        return {m_state == "REQ", fen, fst, iv, m_state == "FLUSH", m_state != "IDLE", m_terr};
    endfunction

    function automatic void model_step();
        bit acc;
        if (rst) begin
            m_state = "IDLE"; m_waited = 0; m_drop = 0; m_terr = 0; m_stall = 0; m_fetch = 0;
            return;
        end
        acc = model_accept();
        if (m_state == "HOLD" && m_stall < CNT_MAX) m_stall++;
        if (acc && m_fetch < CNT_MAX) m_fetch++;
        if (m_state == "IDLE") begin
            if (start) m_state = "REQ";
        end else if (m_state == "REQ") begin
            m_waited = 0;
            if (redirect) begin m_state = "FLUSH"; m_drop = 1; end
            else m_state = "WAIT";
        end else if (m_state == "WAIT") begin
            if (redirect) begin m_state = "FLUSH"; m_drop = !icache_resp_valid; end
            else if (!icache_resp_valid) begin
                if (m_waited == TIMEOUT - 1) begin m_terr = 1; m_state = "IDLE"; end
                else m_waited++;
            end
            else if (m_drop) begin m_drop = 0; m_state = "REQ"; end
            else m_state = acc ? "REQ" : "HOLD";
        end else if (m_state == "HOLD") begin
            if (redirect) m_state = "FLUSH";
            else if (acc) m_state = "REQ";
        end else begin
            if (icache_resp_valid) m_drop = 0;
            m_state = redirect ? "FLUSH" : "REQ";
        end
    endfunction

    task automatic drive(input logic s, rp, dr, hz, rd, rs);
        start = s; icache_resp_valid = rp; decode_ready = dr;
        hazard_stall = hz; redirect = rd; rst = rs;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 1);
        advance();
        advance();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 1, 1);
            @(negedge clk);
            checks++;
            if (dut_outs !== 7'b0) begin
                errors++; $display("FAIL reset_during cycle %0d: got %b expected %b", i, dut_outs, 7'b0);
            end
            advance();
        end
        drive(0, 1, 1, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (dut_outs !== 7'b0) begin
            errors++; $display("FAIL reset_after: got %b expected %b", dut_outs, 7'b0);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt !== '0 || perf_fetch_cnt !== '0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall_cnt, perf_fetch_cnt);
        end
`endif
        advance();
    endtask

    task automatic test_stream();
        int pulses = 0;
        do_reset();
        drive(1, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (dut_outs !== exp_outs()) begin
            errors++; $display("FAIL stream_start: got %b expected %b", dut_outs, exp_outs());
        end
        advance();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (dut_outs !== exp_outs()) begin
                errors++; $display("FAIL stream_outs cycle %0d: got %b expected %b", i, dut_outs, exp_outs());
            end
            checks++;
            if (fetch_enable_control !== (i % 2 == 1)) begin
                errors++; $display("FAIL stream_enable cycle %0d: got %b expected %b", i, fetch_enable_control, (i % 2 == 1));
            end
            if (fetch_enable_control) pulses++;
            advance();
        end
        checks++;
        if (pulses !== 4) begin
            errors++; $display("FAIL stream_count: got %0d expected 4", pulses);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 4'd4) begin
            errors++; $display("FAIL stream_perf_fetch: got %0d expected 4", perf_fetch_cnt);
        end
`endif
    endtask

    task automatic test_hold();
        logic [4:0] stim [0:6];
        logic [2:0] exp3 [0:6];
        stim = '{5'b10000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
        exp3 = '{3'b000, 3'b000, 3'b011, 3'b011, 3'b011, 3'b101, 3'b000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0], 1'b0);
            @(negedge clk);
            checks++;
            if (dut_outs !== exp_outs()) begin
                errors++; $display("FAIL hold_outs row %0d: got %b expected %b", i, dut_outs, exp_outs());
            end
            checks++;
            if ({fetch_enable_control, fetch_stall_control, instr_valid} !== exp3[i]) begin
                errors++; $display("FAIL hold_en_st_iv row %0d: got %b expected %b", i,
                                   {fetch_enable_control, fetch_stall_control, instr_valid}, exp3[i]);
            end
            advance();
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt !== 4'd3 || perf_fetch_cnt !== 4'd1) begin
            errors++; $display("FAIL hold_perf: got stall=%0d fetch=%0d expected 3/1", perf_stall_cnt, perf_fetch_cnt);
        end
`endif
    endtask

    task automatic test_redirect();
        logic [4:0] stim [0:8];
        logic [3:0] exp4 [0:8];
        int delivered = 0;
        stim = '{5'b10100, 5'b00100, 5'b00101, 5'b00100, 5'b00100, 5'b01100, 5'b00100, 5'b01100, 5'b00100};
        exp4 = '{4'b0000, 4'b1000, 4'b0000, 4'b0101, 4'b1000, 4'b0000, 4'b1000, 4'b0110, 4'b1000};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0], 1'b0);
            @(negedge clk);
            checks++;
            if (dut_outs !== exp_outs()) begin
                errors++; $display("FAIL redirect_outs row %0d: got %b expected %b", i, dut_outs, exp_outs());
            end
            checks++;
            if ({icache_req, fetch_enable_control, instr_valid, flush} !== exp4[i]) begin
                errors++; $display("FAIL redirect_req_en_iv_fl row %0d: got %b expected %b", i,
                                   {icache_req, fetch_enable_control, instr_valid, flush}, exp4[i]);
            end
            if (instr_valid) delivered++;
            advance();
        end
        checks++;
        if (delivered !== 1) begin
            errors++; $display("FAIL redirect_delivered: got %0d expected 1", delivered);
        end
    endtask

    task automatic test_timeout();
        int waits = 0;
        bit done = 0;
        do_reset();
        drive(1, 0, 1, 0, 0, 0);
        advance();
        for (int i = 0; i < 20 && !done; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (dut_outs !== exp_outs()) begin
                errors++; $display("FAIL timeout_outs cycle %0d: got %b expected %b", i, dut_outs, exp_outs());
            end
            if (!busy) done = 1;
            else if (!icache_req) waits++;
            advance();
        end
        checks++;
        if (!done || waits !== TIMEOUT) begin
            errors++; $display("FAIL timeout_wait_cycles: got %0d (idle=%0b) expected %0d", waits, done, TIMEOUT);
        end
        drive(1, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({busy, timeout_err} !== 2'b01) begin
            errors++; $display("FAIL timeout_idle: got busy/err=%b expected 01", {busy, timeout_err});
        end
        advance();
        drive(0, 0, 1, 0, 0, 0);
        advance();
        drive(0, 1, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({busy, instr_valid, fetch_enable_control, timeout_err} !== 4'b1111) begin
            errors++; $display("FAIL timeout_restart: got %b expected 1111",
                               {busy, instr_valid, fetch_enable_control, timeout_err});
        end
        advance();
        do_reset();
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_cleared: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 0, 0, 0, 0); advance();
        drive(0, 0, 0, 0, 0, 0); advance();
        drive(0, 1, 0, 0, 0, 0); advance();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({instr_valid, fetch_stall_control, busy} !== 3'b111) begin
            errors++; $display("FAIL rstmid_hold: got %b expected 111", {instr_valid, fetch_stall_control, busy});
        end
        drive(0, 1, 1, 0, 1, 1);
        @(negedge clk);
        checks++;
        if (dut_outs !== 7'b0) begin
            errors++; $display("FAIL rstmid_during: got %b expected %b", dut_outs, 7'b0);
        end
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 1, 0);
            @(negedge clk);
            checks++;
            if (dut_outs !== 7'b0 || dut_outs !== exp_outs()) begin
                errors++; $display("FAIL rstmid_after cycle %0d: got %b expected %b", i, dut_outs, 7'b0);
            end
            advance();
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt !== '0 || perf_fetch_cnt !== '0) begin
            errors++; $display("FAIL rstmid_perf: got %0d/%0d expected 0/0", perf_stall_cnt, perf_fetch_cnt);
        end
`endif
    endtask

    task automatic test_hazard();
        logic [4:0] stim [0:7];
        logic [2:0] exp3 [0:7];
        int pulses = 0;
        stim = '{5'b10110, 5'b00110, 5'b01110, 5'b00110, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
        exp3 = '{3'b000, 3'b000, 3'b011, 3'b011, 3'b101, 3'b000, 3'b010, 3'b010};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0], 1'b0);
            @(negedge clk);
            checks++;
            if ({fetch_enable_control, fetch_stall_control, instr_valid} !== exp3[i]) begin
                errors++; $display("FAIL hazard_en_st_iv row %0d: got %b expected %b", i,
                                   {fetch_enable_control, fetch_stall_control, instr_valid}, exp3[i]);
            end
            checks++;
            if (dut_outs !== exp_outs()) begin
                errors++; $display("FAIL hazard_outs row %0d: got %b expected %b", i, dut_outs, exp_outs());
            end
            if (fetch_enable_control) pulses++;
            advance();
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL hazard_consumed: got %0d expected 1", pulses);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 4'd1) begin
            errors++; $display("FAIL hazard_perf_fetch: got %0d expected 1", perf_fetch_cnt);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 30, $urandom_range(99) < 45, $urandom_range(99) < 70,
                  $urandom_range(99) < 20, $urandom_range(99) < 8,  $urandom_range(199) == 0);
            @(negedge clk);
            checks++;
            if (dut_outs !== exp_outs()) begin
                errors++; $display("FAIL random_outs cycle %0d: got %b expected %b", i, dut_outs, exp_outs());
            end
            checks++;
            if (fetch_enable_control && fetch_stall_control) begin
                errors++; $display("FAIL random_en_stall_excl cycle %0d: got en=1 stall=1 expected not both", i);
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (perf_stall_cnt !== CNT_W'(m_stall) || perf_fetch_cnt !== CNT_W'(m_fetch)) begin
                errors++; $display("FAIL random_perf cycle %0d: got %0d/%0d expected %0d/%0d",
                                   i, perf_stall_cnt, perf_fetch_cnt, m_stall, m_fetch);
            end
`endif
            advance();
        end
    endtask

    initial begin
        m_state = "IDLE"; m_waited = 0; m_drop = 0; m_terr = 0; m_stall = 0; m_fetch = 0;
        drive(0, 0, 0, 0, 0, 1);
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_timeout();
        test_reset_mid();
        test_hazard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
